// File: rtl/fpu_writeback_regfile_if.sv
// Issue / write-back / read-port bundle between the FPU issue logic and the
// float register file with scoreboard.
interface fpu_writeback_regfile_if #(
  parameter int DW   = 32,
  parameter int LATW = 3
);
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [DW-1:0]   rdata1;
  logic [DW-1:0]   rdata2;
  logic            issue_valid;
  logic [4:0]      issue_rd;
  logic [LATW-1:0] issue_lat;
  logic            stall;
  logic            wb_valid;
  logic [4:0]      wb_rd;
  logic [DW-1:0]   wb_data;
  logic            busy1;
  logic            busy2;
  logic [5:0]      pending_cnt;
  logic            wb_err;
  logic            tmo_err;

  modport master (
    output rs1, rs2, issue_valid, issue_rd, issue_lat, wb_valid, wb_rd, wb_data,
    input  rdata1, rdata2, stall, busy1, busy2, pending_cnt, wb_err, tmo_err
  );

  modport slave (
    input  rs1, rs2, issue_valid, issue_rd, issue_lat, wb_valid, wb_rd, wb_data,
    output rdata1, rdata2, stall, busy1, busy2, pending_cnt, wb_err, tmo_err
  );
endinterface

// File: rtl/fpu_writeback_regfile.sv
// Float register file with per-register write-back scoreboard: tracks the
// expected write-back edge of each issued op and flags early/late/missing ones.
module fpu_wb_slot #(
  parameter int DW   = 32,
  parameter int LATW = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wb_hit,
  input  logic            iss_hit,
  input  logic [DW-1:0]   wb_data,
  input  logic [LATW-1:0] issue_lat,
  output logic [DW-1:0]   data,
  output logic            busy,
  output logic [LATW-1:0] cnt,
  output logic            busy_nxt,
  output logic            tmo
);
  logic [LATW-1:0] cnt_nxt;

  assign tmo = busy && (cnt == LATW'(1)) && !wb_hit;

  // A same-edge issue re-arms the slot even when a write-back lands on it.
  always_comb begin
    busy_nxt = busy;
    cnt_nxt  = cnt;
    if (iss_hit) begin
      busy_nxt = 1'b1;
      cnt_nxt  = (issue_lat == '0) ? LATW'(1) : issue_lat;
    end else if (wb_hit) begin
      busy_nxt = 1'b0;
      cnt_nxt  = '0;
    end else if (busy) begin
      if (cnt <= LATW'(1)) begin
        busy_nxt = 1'b0;
        cnt_nxt  = '0;
      end else begin
        cnt_nxt = cnt - LATW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      busy <= 1'b0;
      cnt  <= '0;
    end else begin
      if (wb_hit) data <= wb_data;
      busy <= busy_nxt;
      cnt  <= cnt_nxt;
    end
  end
endmodule

module fpu_writeback_regfile #(
  parameter int NREG = 32,
  parameter int DW   = 32,
  parameter int LATW = 3
) (
  input logic                   clk,
  input logic                   rst_n,
  fpu_writeback_regfile_if.slave bus
);
  logic [NREG-1:0][DW-1:0]   regs;
  logic [NREG-1:0][LATW-1:0] cnt;
  logic [NREG-1:0]           busy, busy_nxt, eb, wb_hit, iss_hit, tmo;
  logic                      stall_c, issue_ok, wb_ontime;
  logic [5:0]                pending_q;
  logic                      wb_err_q, tmo_err_q;

  for (genvar i = 0; i < NREG; i++) begin : g_dec
    assign wb_hit[i]  = bus.wb_valid && (bus.wb_rd == 5'(i));
    assign iss_hit[i] = issue_ok && (bus.issue_rd == 5'(i));
  end

  // A register being written back this cycle is already free for readers/issuers.
  assign eb       = busy & ~wb_hit;
  assign stall_c  = bus.issue_valid && (eb[bus.rs1] || eb[bus.rs2] || eb[bus.issue_rd]);
  assign issue_ok = bus.issue_valid && !stall_c;

  fpu_wb_slot #(.DW(DW), .LATW(LATW)) u_slot [NREG-1:0] (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_hit    (wb_hit),
    .iss_hit   (iss_hit),
    .wb_data   (bus.wb_data),
    .issue_lat (bus.issue_lat),
    .data      (regs),
    .busy      (busy),
    .cnt       (cnt),
    .busy_nxt  (busy_nxt),
    .tmo       (tmo)
  );

  assign wb_ontime = busy[bus.wb_rd] && (cnt[bus.wb_rd] == LATW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      wb_err_q  <= 1'b0;
      tmo_err_q <= 1'b0;
    end else begin
      pending_q <= 6'($countones(busy_nxt));
      wb_err_q  <= bus.wb_valid && !wb_ontime;
      tmo_err_q <= |tmo;
    end
  end

  assign bus.rdata1      = wb_hit[bus.rs1] ? bus.wb_data : regs[bus.rs1];
  assign bus.rdata2      = wb_hit[bus.rs2] ? bus.wb_data : regs[bus.rs2];
  assign bus.busy1       = eb[bus.rs1];
  assign bus.busy2       = eb[bus.rs2];
  assign bus.stall       = stall_c;
  assign bus.pending_cnt = pending_q;
  assign bus.wb_err      = wb_err_q;
  assign bus.tmo_err     = tmo_err_q;
endmodule

// File: tb/tb_fpu_writeback_regfile.sv
// Vector table + scoreboard bench for the float regfile write-back scoreboard.
module tb_fpu_writeback_regfile;
  logic clk, rst_n;
  int   checks = 0;
  int   errors = 0;

  fpu_writeback_regfile_if #(.DW(32), .LATW(3)) bus ();

  fpu_writeback_regfile #(.NREG(32), .DW(32), .LATW(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1, rs2;
    logic        iv;
    logic [4:0]  ird;
    logic [2:0]  lat;
    logic        wv;
    logic [4:0]  wrd;
    logic [31:0] wd;
    logic [31:0] r1, r2;
    logic        st, b1, b2;
    logic [5:0]  pc;
    logic        we, te;
  } vec_t;

  localparam int NV = 40;
  vec_t tbl [NV];
  vec_t exp_q [$];
  vec_t e;

  function automatic vec_t v(input logic [4:0] rs1, rs2, input logic iv,
                             input logic [4:0] ird, input logic [2:0] lat,
                             input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                             input logic [31:0] r1, r2, input logic st, b1, b2,
                             input logic [5:0] pc, input logic we, te);
    vec_t t;
    t.rs1 = rs1; t.rs2 = rs2; t.iv = iv; t.ird = ird; t.lat = lat;
    t.wv = wv; t.wrd = wrd; t.wd = wd; t.r1 = r1; t.r2 = r2;
    t.st = st; t.b1 = b1; t.b2 = b2; t.pc = pc; t.we = we; t.te = te;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] rs1, rs2, input logic iv, input logic [4:0] ird,
                       input logic [2:0] lat, input logic wv, input logic [4:0] wrd,
                       input logic [31:0] wd);
    bus.rs1 = rs1; bus.rs2 = rs2; bus.issue_valid = iv; bus.issue_rd = ird;
    bus.issue_lat = lat; bus.wb_valid = wv; bus.wb_rd = wrd; bus.wb_data = wd;
  endtask

  initial begin
    //            rs1 rs2 iv ird lat wv wrd wd           | r1           r2           st b1 b2 pc we te
    tbl[0]  = v(3,  0, 1, 3, 4, 0, 0, 0,                   0,           0,           0, 0, 0, 1, 0, 0);
    tbl[1]  = v(3,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 1, 0, 0);
    tbl[2]  = v(3,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 1, 0, 0);
    tbl[3]  = v(3,  0, 1, 4, 1, 0, 0, 0,                   0,           0,           1, 1, 0, 1, 0, 0);
    tbl[4]  = v(3,  0, 0, 0, 0, 1, 3, 32'h3F800000,        32'h3F800000, 0,          0, 0, 0, 0, 0, 0);
    tbl[5]  = v(3,  0, 0, 0, 0, 0, 0, 0,                   32'h3F800000, 0,          0, 0, 0, 0, 0, 0);
    tbl[6]  = v(5,  0, 1, 5, 1, 0, 0, 0,                   0,           0,           0, 0, 0, 1, 0, 0);
    tbl[7]  = v(5,  0, 0, 0, 0, 1, 5, 32'h40000000,        32'h40000000, 0,          0, 0, 0, 0, 0, 0);
    tbl[8]  = v(5,  0, 0, 0, 0, 0, 0, 0,                   32'h40000000, 0,          0, 0, 0, 0, 0, 0);
    tbl[9]  = v(0,  7, 1, 7, 3, 0, 0, 0,                   0,           0,           0, 0, 0, 1, 0, 0);
    tbl[10] = v(0,  7, 1, 8, 2, 0, 0, 0,                   0,           0,           1, 0, 1, 1, 0, 0);
    tbl[11] = v(0,  7, 1, 8, 2, 0, 0, 0,                   0,           0,           1, 0, 1, 1, 0, 0);
    tbl[12] = v(0,  7, 1, 8, 2, 1, 7, 32'h11111111,        0,           32'h11111111, 0, 0, 0, 1, 0, 0);
    tbl[13] = v(8,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 1, 0, 0);
    tbl[14] = v(8,  0, 0, 0, 0, 1, 8, 32'h22222222,        32'h22222222, 0,          0, 0, 0, 0, 0, 0);
    tbl[15] = v(2,  0, 1, 2, 2, 0, 0, 0,                   0,           0,           0, 0, 0, 1, 0, 0);
    tbl[16] = v(2,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 1, 0, 0);
    tbl[17] = v(2,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 0, 0, 1);
    tbl[18] = v(2,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 0, 0, 0, 0, 0);
    tbl[19] = v(2,  0, 0, 0, 0, 1, 2, 32'h33333333,        32'h33333333, 0,          0, 0, 0, 0, 1, 0);
    tbl[20] = v(2,  0, 0, 0, 0, 0, 0, 0,                   32'h33333333, 0,          0, 0, 0, 0, 0, 0);
    tbl[21] = v(9,  0, 1, 9, 5, 0, 0, 0,                   0,           0,           0, 0, 0, 1, 0, 0);
    tbl[22] = v(9,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 1, 0, 0);
    tbl[23] = v(9,  0, 0, 0, 0, 0, 0, 0,                   0,           0,           0, 1, 0, 1, 0, 0);
    tbl[24] = v(9,  0, 0, 0, 0, 1, 9, 32'h44444444,        32'h44444444, 0,          0, 0, 0, 0, 1, 0);
    tbl[25] = v(9,  0, 0, 0, 0, 0, 0, 0,                   32'h44444444, 0,          0, 0, 0, 0, 0, 0);
    tbl[26] = v(10, 0, 1, 10, 0, 0, 0, 0,                  0,           0,           0, 0, 0, 1, 0, 0);
    tbl[27] = v(10, 0, 0, 0, 0, 1, 10, 32'h55,             32'h55,      0,           0, 0, 0, 0, 0, 0);
    tbl[28] = v(11, 0, 1, 11, 3, 0, 0, 0,                  0,           0,           0, 0, 0, 1, 0, 0);
    tbl[29] = v(0,  0, 1, 11, 1, 0, 0, 0,                  0,           0,           1, 0, 0, 1, 0, 0);
    tbl[30] = v(11, 0, 1, 11, 2, 1, 11, 32'h66,            32'h66,      0,           0, 0, 0, 1, 1, 0);
    tbl[31] = v(11, 0, 0, 0, 0, 0, 0, 0,                   32'h66,      0,           0, 1, 0, 1, 0, 0);
    tbl[32] = v(11, 0, 0, 0, 0, 1, 11, 32'h77,             32'h77,      0,           0, 0, 0, 0, 0, 0);
    tbl[33] = v(11, 0, 0, 0, 0, 0, 0, 0,                   32'h77,      0,           0, 0, 0, 0, 0, 0);
    tbl[34] = v(0,  0, 0, 0, 0, 1, 0, 32'h88,              32'h88,      32'h88,      0, 0, 0, 0, 1, 0);
    tbl[35] = v(0,  0, 0, 0, 0, 0, 0, 0,                   32'h88,      32'h88,      0, 0, 0, 0, 0, 0);
    tbl[36] = v(12, 0, 1, 12, 2, 0, 0, 0,                  0,           32'h88,      0, 0, 0, 1, 0, 0);
    tbl[37] = v(13, 0, 1, 13, 1, 0, 0, 0,                  0,           32'h88,      0, 0, 0, 2, 0, 0);
    tbl[38] = v(12, 13, 0, 0, 0, 0, 0, 0,                  0,           0,           0, 1, 1, 0, 0, 1);
    tbl[39] = v(12, 13, 0, 0, 0, 0, 0, 0,                  0,           0,           0, 0, 0, 0, 0, 0);

    // Reset state, with an issue request present to show stall stays low.
    rst_n = 1'b0;
    drive(3, 0, 1, 3, 4, 0, 0, 0);
    #3;
    chk("rst_pending", 32'(bus.pending_cnt), 0);
    chk("rst_wb_err",  32'(bus.wb_err), 0);
    chk("rst_tmo_err", 32'(bus.tmo_err), 0);
    chk("rst_rdata1",  bus.rdata1, 0);
    chk("rst_busy1",   32'(bus.busy1), 0);
    chk("rst_stall",   32'(bus.stall), 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    #9 rst_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      drive(tbl[i].rs1, tbl[i].rs2, tbl[i].iv, tbl[i].ird, tbl[i].lat,
            tbl[i].wv, tbl[i].wrd, tbl[i].wd);
      exp_q.push_back(tbl[i]);
      #1;
      e = exp_q[0];
      chk($sformatf("v%0d_rdata1", i), bus.rdata1, e.r1);
      chk($sformatf("v%0d_rdata2", i), bus.rdata2, e.r2);
      chk($sformatf("v%0d_stall", i),  32'(bus.stall), 32'(e.st));
      chk($sformatf("v%0d_busy1", i),  32'(bus.busy1), 32'(e.b1));
      chk($sformatf("v%0d_busy2", i),  32'(bus.busy2), 32'(e.b2));
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      chk($sformatf("v%0d_pending", i), 32'(bus.pending_cnt), 32'(e.pc));
      chk($sformatf("v%0d_wb_err", i),  32'(bus.wb_err), 32'(e.we));
      chk($sformatf("v%0d_tmo_err", i), 32'(bus.tmo_err), 32'(e.te));
    end

    // Three ops in flight, then asynchronous reset mid-cycle.
    @(negedge clk); drive(0, 0, 1, 20, 7, 0, 0, 0);
    @(negedge clk); drive(0, 0, 1, 21, 7, 0, 0, 0);
    @(negedge clk); drive(0, 0, 1, 22, 7, 0, 0, 0);
    @(negedge clk); drive(20, 3, 0, 0, 0, 0, 0, 0);
    #1;
    chk("pre_rst_pending", 32'(bus.pending_cnt), 3);
    chk("pre_rst_busy1",   32'(bus.busy1), 1);
    chk("pre_rst_rdata2",  bus.rdata2, 32'h3F800000);
    #1 rst_n = 1'b0;
    bus.issue_valid = 1'b1; bus.issue_rd = 20;
    #1;
    chk("mid_rst_pending", 32'(bus.pending_cnt), 0);
    chk("mid_rst_busy1",   32'(bus.busy1), 0);
    chk("mid_rst_rdata2",  bus.rdata2, 0);
    chk("mid_rst_stall",   32'(bus.stall), 0);
    bus.issue_valid = 1'b0;
    @(negedge clk); #2 rst_n = 1'b1;

    // A write-back for the discarded op is now unexpected.
    @(negedge clk); drive(20, 0, 0, 0, 0, 1, 20, 32'h99);
    @(posedge clk); #1;
    chk("post_rst_wb_err",  32'(bus.wb_err), 1);
    chk("post_rst_pending", 32'(bus.pending_cnt), 0);
    @(negedge clk); drive(20, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("post_rst_rdata1", bus.rdata1, 32'h99);
    @(posedge clk); #1;
    chk("post_rst_wb_err_clr", 32'(bus.wb_err), 0);
    chk("post_rst_tmo_err",    32'(bus.tmo_err), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
